// File: rtl/lz77_pkg.sv
// Shared LZ77 definitions: window geometry, token layout and decoder states.
// Used by both the compressor and the decompressor so their windows agree.
package lz77_pkg;

    localparam int windowSize         = 4095;
    localparam int windowAddressBits  = 12;
    localparam int lengthBits         = 6;
    localparam int minimumMatchLength = 3;

    localparam logic flagLiteral = 1'b1;
    localparam logic flagMatch   = 1'b0;

    localparam int literalTokenBits = 1 + 8;
    localparam int matchTokenBits   = 1 + windowAddressBits + lengthBits;

    typedef logic [windowAddressBits-1:0] windowIndex_t;
    typedef logic [lengthBits-1:0]        matchLength_t;

    localparam windowIndex_t windowCapacity = windowIndex_t'(windowSize);

    typedef enum logic [3:0] {
        IDLE, FLAG, LIT, EMIT, OFF, LEN, COPY_RD, COPY_OUT, DONE
    } lz77State_t;

    // windowSize is not a power of two, so wrap by compare-and-subtract; operands are always < windowSize
    function automatic windowIndex_t windowAdd(input windowIndex_t a, input windowIndex_t b);
        logic [windowAddressBits:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= {1'b0, windowCapacity}) begin
            sum = sum - {1'b0, windowCapacity};
        end
        return sum[windowAddressBits-1:0];
    endfunction

endpackage

// File: rtl/lz77_decompressor_if.sv
// Token bit input and byte output handshakes of the LZ77 decompressor.
// master = the environment feeding bits and sinking bytes, slave = the decoder.
interface lz77_decompressor_if;

    logic       inBit;
    logic       inValid;
    logic       inReady;
    logic [7:0] outData;
    logic       outValid;
    logic       outReady;

    modport master (
        output inBit, inValid, outReady,
        input  inReady, outData, outValid
    );

    modport slave (
        input  inBit, inValid, outReady,
        output inReady, outData, outValid
    );

endinterface

// File: rtl/lz77_window_ram.sv
// Single-port history RAM: synchronous read, write enable, old data returned on same-address write.
module lz77_window_ram
    import lz77_pkg::*;
(
    input  logic         clk,
    input  logic         readEnable,
    input  logic         writeEnable,
    input  windowIndex_t address,
    input  logic [7:0]   writeData,
    output logic [7:0]   readData
);

    logic [7:0] mem [windowSize];

    // readData only moves on a read so the decoder can present it while the sink stalls
    always_ff @(posedge clk) begin
        if (readEnable) begin
            readData <= mem[address];
        end
        if (writeEnable) begin
            mem[address] <= writeData;
        end
    end

endmodule

// File: rtl/lz77_decompressor.sv
// Serial LZ77 token decoder: rebuilds the byte stream and mirrors the compressor's history window.
module lz77_decompressor
    import lz77_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               streamEnd,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [31:0]        bytesWritten,
    lz77_decompressor_if.slave stream
);

    lz77State_t   state;
    logic [3:0]   bitCount;
    logic [10:0]  shiftReg;
    windowIndex_t offsetReg;
    windowIndex_t srcIdx;
    windowIndex_t windowPtr;
    windowIndex_t charsInWindow;
    matchLength_t remaining;
    logic [7:0]   literalByte;
    logic [7:0]   ramReadData;
    logic         outValidReg;

    logic                       bitAccept;
    logic                       byteAccept;
    logic                       windowFull;
    logic                       matchBad;
    logic                       ramRead;
    windowIndex_t               appendAddr;
    windowIndex_t               ramAddress;
    matchLength_t               lengthIn;
    logic [windowAddressBits:0] matchEnd;

    assign bitAccept  = stream.inValid && stream.inReady;
    assign byteAccept = outValidReg && stream.outReady;
    assign windowFull = (charsInWindow == windowCapacity);
    assign appendAddr = windowFull ? windowPtr : windowAdd(windowPtr, charsInWindow);
    assign lengthIn   = {shiftReg[lengthBits-2:0], stream.inBit};
    assign matchEnd   = {1'b0, offsetReg} + {{(windowAddressBits + 1 - lengthBits){1'b0}}, lengthIn};
    assign matchBad   = (lengthIn < matchLength_t'(minimumMatchLength)) || (matchEnd > {1'b0, charsInWindow});
    assign ramRead    = (state == COPY_RD);
    assign ramAddress = ramRead ? srcIdx : appendAddr;

    assign stream.inReady  = (state == FLAG) || (state == LIT) || (state == OFF) || (state == LEN);
    assign stream.outValid = outValidReg;
    assign stream.outData  = (state == COPY_OUT) ? ramReadData : literalByte;

    lz77_window_ram windowRam (
        .clk         (clk),
        .readEnable  (ramRead),
        .writeEnable (byteAccept),
        .address     (ramAddress),
        .writeData   (stream.outData),
        .readData    (ramReadData)
    );

    // Once the window is full every new byte overwrites the oldest one and the window origin slides
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            bytesWritten  <= '0;
            bitCount      <= '0;
            shiftReg      <= '0;
            offsetReg     <= '0;
            srcIdx        <= '0;
            windowPtr     <= '0;
            charsInWindow <= '0;
            remaining     <= '0;
            literalByte   <= '0;
            outValidReg   <= 1'b0;
        end else begin
            if (byteAccept) begin
                bytesWritten <= bytesWritten + 32'd1;
                if (windowFull) begin
                    windowPtr <= windowAdd(windowPtr, windowIndex_t'(1));
                end else begin
                    charsInWindow <= charsInWindow + windowIndex_t'(1);
                end
            end

            if (bitAccept) begin
                shiftReg <= {shiftReg[9:0], stream.inBit};
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        state <= FLAG;
                    end
                end
                FLAG: begin
                    if (streamEnd && !stream.inValid) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (bitAccept) begin
                        bitCount <= '0;
                        state    <= (stream.inBit == flagMatch) ? OFF : LIT;
                    end
                end
                LIT: begin
                    if (bitAccept) begin
                        if (bitCount == 4'd7) begin
                            literalByte <= {shiftReg[6:0], stream.inBit};
                            outValidReg <= 1'b1;
                            state       <= EMIT;
                        end else begin
                            bitCount <= bitCount + 4'd1;
                        end
                    end
                end
                EMIT: begin
                    if (byteAccept) begin
                        outValidReg <= 1'b0;
                        state       <= FLAG;
                    end
                end
                OFF: begin
                    if (bitAccept) begin
                        if (bitCount == 4'd11) begin
                            offsetReg <= {shiftReg, stream.inBit};
                            bitCount  <= '0;
                            state     <= LEN;
                        end else begin
                            bitCount <= bitCount + 4'd1;
                        end
                    end
                end
                LEN: begin
                    if (bitAccept) begin
                        if (bitCount == 4'd5) begin
                            // Source is fixed here so window sliding during the copy cannot move it
                            if (matchBad) begin
                                err   <= 1'b1;
                                state <= FLAG;
                            end else begin
                                srcIdx    <= windowAdd(windowPtr, offsetReg);
                                remaining <= lengthIn;
                                state     <= COPY_RD;
                            end
                        end else begin
                            bitCount <= bitCount + 4'd1;
                        end
                    end
                end
                COPY_RD: begin
                    outValidReg <= 1'b1;
                    state       <= COPY_OUT;
                end
                COPY_OUT: begin
                    if (byteAccept) begin
                        outValidReg <= 1'b0;
                        srcIdx      <= windowAdd(srcIdx, windowIndex_t'(1));
                        remaining   <= remaining - matchLength_t'(1);
                        state       <= (remaining == matchLength_t'(1)) ? FLAG : COPY_RD;
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lz77_decompressor.sv
// Directed and randomized token streams checked against a byte-history model of LZ77 decoding.
module tb_lz77_decompressor;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        streamEnd;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] bytesWritten;

    lz77_decompressor_if stream ();

    lz77_decompressor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .streamEnd    (streamEnd),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .bytesWritten (bytesWritten),
        .stream       (stream)
    );

    int vectorCount = 0;
    int missCount   = 0;
    int readyMode   = 0;

    byte unsigned history[$];
    byte unsigned expected[$];
    byte unsigned captured[$];
    logic         expectErr;
    logic         stalled;
    logic [7:0]   stalledData;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] required);
        vectorCount++;
        assert (observed === required)
        else begin
            missCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, required);
        end
    endtask

    // Sink readiness pattern: 0 always, 1 toggling, 2 random, otherwise never
    initial stream.outReady = 1'b0;
    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       stream.outReady = 1'b1;
            1:       stream.outReady = ~stream.outReady;
            2:       stream.outReady = 1'($urandom_range(0, 1));
            default: stream.outReady = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (stalled && stream.outValid)
                checkOutput("holdStable", 32'(stream.outData), 32'(stalledData));
            if (stream.outValid)
                checkOutput("inReadyLowWhileOut", 32'(stream.inReady), 32'd0);
            if (stream.outValid && stream.outReady)
                captured.push_back(stream.outData);
            stalled     = stream.outValid && !stream.outReady;
            stalledData = stream.outData;
        end else begin
            stalled = 1'b0;
        end
    end

    function automatic int windowChars();
        return (history.size() < 4095) ? history.size() : 4095;
    endfunction

    task automatic sendBit(input logic b);
        int   guard = 0;
        logic taken = 1'b0;
        stream.inBit   = b;
        stream.inValid = 1'b1;
        while (!taken && guard < 2000) begin
            @(negedge clk);
            taken = stream.inReady;
            @(posedge clk);
            #1;
            guard++;
        end
        stream.inValid = 1'b0;
        if (!taken) checkOutput("bitAcceptTimeout", 32'(taken), 32'd1);
    endtask

    task automatic applyStimulus(input logic [18:0] token, input int width);
        for (int i = width - 1; i >= 0; i--) sendBit(token[i]);
    endtask

    task automatic sendLiteral(input byte unsigned value);
        applyStimulus({10'b0, 1'b1, value}, 9);
        history.push_back(value);
        expected.push_back(value);
    endtask

    // Offset counts from the oldest byte still in the window
    task automatic sendMatch(input int offset, input int length);
        int chars;
        int base;
        byte unsigned b;
        applyStimulus({1'b0, 12'(offset), 6'(length)}, 19);
        chars = windowChars();
        if (length < 3 || offset + length > chars) begin
            expectErr = 1'b1;
        end else begin
            base = history.size() - chars;
            for (int k = 0; k < length; k++) begin
                b = history[base + offset + k];
                history.push_back(b);
                expected.push_back(b);
            end
        end
    endtask

    task automatic drainOutput(input string tag);
        int guard = 0;
        while ((captured.size() < expected.size() || stream.outValid) && guard < 3000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput({tag, "Count"}, 32'(captured.size()), 32'(expected.size()));
        while (captured.size() > 0 && expected.size() > 0)
            checkOutput({tag, "Byte"}, 32'(captured.pop_front()), 32'(expected.pop_front()));
        captured.delete();
        expected.delete();
        checkOutput({tag, "BytesWritten"}, bytesWritten, 32'(history.size()));
        checkOutput({tag, "Err"}, 32'(err), 32'(expectErr));
    endtask

    task automatic applyReset();
        rst_n          = 1'b0;
        start          = 1'b0;
        streamEnd      = 1'b0;
        stream.inValid = 1'b0;
        stream.inBit   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        history.delete();
        expected.delete();
        captured.delete();
        expectErr = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        int chars;
        int len;
        int off;

        readyMode = 0;
        applyReset();
        rst_n = 1'b0;
        #1;
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetDone", 32'(done), 32'd0);
        checkOutput("resetErr", 32'(err), 32'd0);
        checkOutput("resetOutValid", 32'(stream.outValid), 32'd0);
        checkOutput("resetOutData", 32'(stream.outData), 32'd0);
        checkOutput("resetBytesWritten", bytesWritten, 32'd0);
        checkOutput("resetInReady", 32'(stream.inReady), 32'd0);

        $display("[TB] literal tokens");
        applyReset();
        pulseStart();
        checkOutput("busyAfterStart", 32'(busy), 32'd1);
        sendLiteral(8'h41);
        sendLiteral(8'h42);
        drainOutput("literal");
        checkOutput("literalCount", bytesWritten, 32'd2);

        $display("[TB] basic match");
        applyReset();
        pulseStart();
        sendLiteral("a");
        sendLiteral("b");
        sendLiteral("c");
        sendMatch(0, 3);
        drainOutput("match");

        $display("[TB] backpressure on a long copy");
        for (int i = 0; i < 61; i++) sendLiteral(8'($urandom));
        drainOutput("bpPrefix");
        readyMode = 1;
        sendMatch(1, 63);
        drainOutput("backpressure");

        $display("[TB] window wrap");
        readyMode = 0;
        applyReset();
        pulseStart();
        for (int i = 0; i < 4100; i++) sendLiteral(8'($urandom));
        drainOutput("wrapFill");
        sendMatch(0, 4);
        drainOutput("wrapOldest");
        sendMatch(4090, 5);
        drainOutput("wrapNewest");

        $display("[TB] malformed match");
        applyReset();
        pulseStart();
        sendMatch(0, 3);
        sendLiteral(8'h5A);
        drainOutput("errEmpty");
        sendMatch(0, 2);
        sendLiteral(8'hC3);
        drainOutput("errShort");

        $display("[TB] random token stream");
        readyMode = 2;
        applyReset();
        pulseStart();
        for (int t = 0; t < 150; t++) begin
            chars = windowChars();
            if (chars < 3 || $urandom_range(0, 2) == 0) begin
                sendLiteral(8'($urandom));
            end else if ($urandom_range(0, 19) == 0) begin
                sendMatch(chars, 3);
            end else begin
                len = $urandom_range(3, (chars < 63) ? chars : 63);
                off = $urandom_range(0, chars - len);
                sendMatch(off, len);
            end
        end
        drainOutput("random");

        $display("[TB] stream end");
        readyMode = 0;
        streamEnd = 1'b1;
        sendLiteral(8'h77);
        repeat (4) @(posedge clk);
        #1;
        drainOutput("endTail");
        checkOutput("endDone", 32'(done), 32'd1);
        checkOutput("endBusy", 32'(busy), 32'd0);
        checkOutput("endInReady", 32'(stream.inReady), 32'd0);
        streamEnd = 1'b0;
        pulseStart();
        checkOutput("doneSticky", 32'(done), 32'd1);

        $display("[TB] reset during copy");
        applyReset();
        pulseStart();
        for (int i = 0; i < 10; i++) sendLiteral(8'($urandom));
        drainOutput("preAbort");
        readyMode = 3;
        sendMatch(0, 10);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("copyStalledValid", 32'(stream.outValid), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abortOutValid", 32'(stream.outValid), 32'd0);
        checkOutput("abortOutData", 32'(stream.outData), 32'd0);
        checkOutput("abortBusy", 32'(busy), 32'd0);
        checkOutput("abortBytesWritten", bytesWritten, 32'd0);
        checkOutput("abortErr", 32'(err), 32'd0);
        readyMode = 0;
        applyReset();
        pulseStart();
        sendMatch(0, 3);
        sendLiteral(8'h11);
        drainOutput("afterAbort");

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
